smvm_stream_tx: RTL



---
 rtl/smvm_pkg.sv | 47 ++++
 rtl/smvm_tx_fetch.sv | 103 ++++++++++
 rtl/smvm_stream_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/smvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smvm_pkg
//  Description : Shared state encoding, stream field widths and memory entry
//                bit positions for the SMVM stream transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package smvm_pkg;

    // Transmitter phases; the state names the content on the stream lines
    // during that cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_HDR  = 3'd2,
        S_VEC  = 3'd3,
        S_MAT  = 3'd4,
        S_TERM = 3'd5
    } smvm_state_e;

    // Consumer vector depth.
    localparam int SMVM_VEC_MAX = 128;

    // Stream field widths.
    localparam int VAL_W = 8;
    localparam int COL_W = 8;

    // Memory word layout: [16] row-start, [15:8] column, [7:0] value.
    localparam int ENTRY_W = 17;
    localparam int IPV_BIT = 16;
    localparam int COL_MSB = 15;
    localparam int COL_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    // A job is unusable when either dimension is empty or the vector would
    // overflow the consumer's storage.
    function automatic logic cfg_bad(
        input logic [VAL_W-1:0] rows,
        input logic [COL_W-1:0] cols,
        input int               vec_max
    );
        return (rows == '0) || (cols == '0) || (int'(cols) > vec_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/smvm_tx_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : smvm_tx_fetch
//  Description : Read address generator for the SMVM transmitter. Issues one
//                read per cycle, vector words first then nonzero entries, and
//                carries the phase tag of each read alongside the returning
//                data through a 1-deep pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module smvm_tx_fetch
    import smvm_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = '0,
    parameter logic [ADDR_W-1:0] NZ_BASE  = ADDR_W'(16'h0100)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_launch,
    input  logic              i_flush,
    input  logic [COL_W-1:0]  i_cols,
    input  logic [15:0]       i_nnz,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_pipe_valid,
    output logic              o_pipe_mat,
    output logic              o_pipe_last
);

    logic             r_active;
    logic             r_mat;
    logic [COL_W-1:0] r_vcnt;
    logic [15:0]      r_ncnt;

    logic             r_pipe_valid;
    logic             r_pipe_mat;
    logic             r_pipe_last;

    logic             w_vec_last;
    logic             w_mat_last;
    logic             w_last_read;

    assign w_vec_last  = (r_vcnt == i_cols - COL_W'(1));
    assign w_mat_last  = (r_ncnt == i_nnz - 16'd1);
    assign w_last_read = r_mat ? w_mat_last : (w_vec_last && (i_nnz == 16'd0));

    assign o_mem_rd   = r_active;
    assign o_mem_addr = r_mat ? (NZ_BASE  + ADDR_W'(r_ncnt))
                              : (VEC_BASE + ADDR_W'(r_vcnt));

    assign o_pipe_valid = r_pipe_valid;
    assign o_pipe_mat   = r_pipe_mat;
    assign o_pipe_last  = r_pipe_last;

    // Walk the vector then the nonzero list, one address per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_mat    <= 1'b0;
            r_vcnt   <= '0;
            r_ncnt   <= '0;
        end else if (i_launch) begin
            r_active <= 1'b1;
            r_mat    <= 1'b0;
            r_vcnt   <= '0;
            r_ncnt   <= '0;
        end else if (i_flush) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            if (!r_mat) begin
                r_vcnt <= r_vcnt + COL_W'(1);
                if (w_vec_last) begin
                    if (i_nnz == 16'd0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_mat <= 1'b1;
                    end
                end
            end else begin
                r_ncnt <= r_ncnt + 16'd1;
                if (w_mat_last) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

    // Tag travels with the read so it lines up with mem_rdata; a flush
    // drops the read that is already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_valid <= 1'b0;
            r_pipe_mat   <= 1'b0;
            r_pipe_last  <= 1'b0;
        end else begin
            r_pipe_valid <= r_active && !i_flush;
            r_pipe_mat   <= r_mat;
            r_pipe_last  <= w_last_read;
        end
    end

endmodule
`default_nettype wire

// File: rtl/smvm_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : smvm_stream_tx
//  Description : Transmitter end of the SMVM input stream. Emits a gapless
//                header / vector / nonzero / terminator sequence fetched from
//                a single-port read memory. Optional row-flag checking is
//                enabled with the macro SMVM_TX_ROWCHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module smvm_stream_tx
    import smvm_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0] NZ_BASE  = ADDR_W'(16'h0100),
    parameter int                VEC_MAX  = SMVM_VEC_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VAL_W-1:0]   rows_in,
    input  logic [COL_W-1:0]   cols_in,
    input  logic [15:0]        nnz_in,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [ENTRY_W-1:0] mem_rdata,
    output logic [VAL_W-1:0]   val_out,
    output logic [COL_W-1:0]   col_out,
    output logic               ipv_out,
    output logic               busy,
    output logic               done,
`ifdef SMVM_TX_ROWCHK_EN
    output logic               err_rows,
`endif
    output logic               err_cfg,
    output logic               err_zero
);

    smvm_state_e      r_state;
    smvm_state_e      w_state_nxt;

    logic [VAL_W-1:0] r_rows;
    logic [COL_W-1:0] r_cols;
    logic [15:0]      r_nnz;

    logic [VAL_W-1:0] r_val;
    logic [VAL_W-1:0] w_val_nxt;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_nxt;
    logic             r_ipv;
    logic             w_ipv_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_last;
    logic             w_last_nxt;

    logic             r_err_cfg;
    logic             r_err_zero;

    logic             w_take;
    logic             w_bad;
    logic             w_accept;
    logic             w_flush;

    logic             w_pipe_valid;
    logic             w_pipe_mat;
    logic             w_pipe_last;

    assign w_take   = (r_state == S_IDLE) && start;
    assign w_bad    = cfg_bad(rows_in, cols_in, VEC_MAX);
    assign w_accept = w_take && !w_bad;

    assign val_out  = r_val;
    assign col_out  = r_col;
    assign ipv_out  = r_ipv;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
    assign err_cfg  = r_err_cfg;
    assign err_zero = r_err_zero;

    smvm_tx_fetch #(
        .ADDR_W   (ADDR_W),
        .VEC_BASE (VEC_BASE),
        .NZ_BASE  (NZ_BASE)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_launch     (w_accept),
        .i_flush      (w_flush),
        .i_cols       (r_cols),
        .i_nnz        (r_nnz),
        .o_mem_rd     (mem_rd),
        .o_mem_addr   (mem_addr),
        .o_pipe_valid (w_pipe_valid),
        .o_pipe_mat   (w_pipe_mat),
        .o_pipe_last  (w_pipe_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next stream word; the data arriving from memory this
    // cycle becomes next cycle's stream word.
    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = '0;
        w_col_nxt   = '0;
        w_ipv_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_last_nxt  = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    if (w_bad) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_PREP;
                    end
                end
            end
            S_PREP: begin
                w_state_nxt = S_HDR;
                w_val_nxt   = r_rows;
                w_col_nxt   = r_cols;
            end
            S_HDR, S_VEC, S_MAT: begin
                if (r_last || !w_pipe_valid) begin
                    w_state_nxt = S_TERM;
                    w_done_nxt  = 1'b1;
                end else if (w_pipe_mat) begin
                    if (mem_rdata[VAL_MSB:VAL_LSB] == '0) begin
                        // A zero value would end the consumer early: emit
                        // the terminator in its place and stop fetching.
                        w_state_nxt = S_TERM;
                        w_done_nxt  = 1'b1;
                        w_flush     = 1'b1;
                    end else begin
                        w_state_nxt = S_MAT;
                        w_val_nxt   = mem_rdata[VAL_MSB:VAL_LSB];
                        w_col_nxt   = mem_rdata[COL_MSB:COL_LSB];
                        w_ipv_nxt   = mem_rdata[IPV_BIT];
                        w_last_nxt  = w_pipe_last;
                    end
                end else begin
                    w_state_nxt = S_VEC;
                    w_val_nxt   = mem_rdata[VAL_MSB:VAL_LSB];
                    w_last_nxt  = w_pipe_last;
                end
            end
            S_TERM: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= '0;
            r_col  <= '0;
            r_ipv  <= 1'b0;
            r_done <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_val  <= w_val_nxt;
            r_col  <= w_col_nxt;
            r_ipv  <= w_ipv_nxt;
            r_done <= w_done_nxt;
            r_last <= w_last_nxt;
        end
    end

    // Capture job dimensions whenever a start is seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows <= '0;
            r_cols <= '0;
            r_nnz  <= '0;
        end else if (w_take) begin
            r_rows <= rows_in;
            r_cols <= cols_in;
            r_nnz  <= nnz_in;
        end
    end

    // Sticky error flags; any start in IDLE clears them first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cfg  <= 1'b0;
            r_err_zero <= 1'b0;
        end else if (w_take) begin
            r_err_cfg  <= w_bad;
            r_err_zero <= 1'b0;
        end else if (w_flush) begin
            r_err_zero <= 1'b1;
        end
    end

`ifdef SMVM_TX_ROWCHK_EN
    logic [15:0] r_ipv_cnt;
    logic        r_seen_first;
    logic        r_first_ok;
    logic        r_err_rows;

    assign err_rows = r_err_rows;

    // Count row-start flags in the nonzero phase and judge them at the
    // terminator of a job that ran to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ipv_cnt    <= '0;
            r_seen_first <= 1'b0;
            r_first_ok   <= 1'b0;
            r_err_rows   <= 1'b0;
        end else if (w_accept) begin
            r_ipv_cnt    <= '0;
            r_seen_first <= 1'b0;
            r_first_ok   <= 1'b0;
            r_err_rows   <= 1'b0;
        end else if (w_state_nxt == S_MAT) begin
            r_ipv_cnt <= r_ipv_cnt + 16'(w_ipv_nxt);
            if (!r_seen_first) begin
                r_seen_first <= 1'b1;
                r_first_ok   <= w_ipv_nxt;
            end
        end else if ((w_state_nxt == S_TERM) && !w_flush) begin
            if ((r_ipv_cnt != {8'd0, r_rows}) || !r_first_ok) begin
                r_err_rows <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
